wb_write_arbiter: RTL and testbench
===================================

# wb_write_arbiter

Arbiter and scheduler for the single register-file write port at the end of the pipeline. It shares that port between the in-order write-back stage and a long-latency multiply/divide unit (MDU). MDU results are held in a small FIFO until the port is free, and a pending-destination lookup is exported to hazard detection. It sits between the WB stage / MDU and the register file write port.

## Interface
- DEPTH, 2: MDU result FIFO entries; power of two, ≥2.
- STARVE_LIMIT, 8: cycles the FIFO head may wait before the starvation guard fires; ≥1.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous reset, active-high.
- wb_reg_write  in  1  WB stage requests a register write this cycle.
- wb_dest  in  5  WB destination register.
- wb_data  in  32  WB write data.
- mdu_valid  in  1  MDU offers a result.
- mdu_dest  in  5  MDU destination register.
- mdu_data  in  32  MDU result data.
- mdu_ready  out  1  FIFO can accept; a transfer occurs when mdu_valid && mdu_ready.
- rf_we  out  1  register-file write enable (registered).
- rf_waddr  out  5  register-file write address (registered).
- rf_wdata  out  32  register-file write data (registered).
- stall_req  out  1  asks the pipeline to hold the WB stage (registered).
- chk_addr  in  5  source register queried by hazard logic.
- chk_pending  out  1  combinational; 1 if any live FIFO entry targets chk_addr (chk_addr≠0).

## Operation
- Primary request P = wb_reg_write && wb_dest≠0 && !stall_req. WB writes to $0 are discarded and do not occupy the port.
- Port grant each cycle:
  - If P, WB wins. rf_we/rf_waddr/rf_wdata load WB values.
  - Else if the FIFO holds a live head, pop it and load it to the port.
  - Else rf_we←0; rf_waddr and rf_wdata hold their values.
- Dead FIFO heads are popped silently without using the port, one per cycle, same slot as a live pop.
- MDU accept: an entry with mdu_dest=0 is accepted and dropped (never pushed). Otherwise push {dest, data, live=1}.
- mdu_ready = !full. A pop and a push in the same cycle are both honoured. A full FIFO does not accept even if popping that cycle.
- Supersede rule: when P is granted, every live FIFO entry with dest==wb_dest is marked dead; the newer pipeline write wins. An MDU entry pushed in the same cycle is not affected.
- chk_pending covers live FIFO entries only. It excludes the entry being accepted this cycle and the registered port output.
- Counts and pointers wrap modulo DEPTH; an occupancy counter of width log2(DEPTH)+1 distinguishes full from empty.

## Timing
- Reset values: rf_we=0, rf_waddr=0, rf_wdata=0, stall_req=0, FIFO empty, starvation counter 0.
- mdu_ready=0 while rst is high; it is 1 from the first cycle after reset.
- WB request in cycle N gives rf_we=1 in cycle N+1.
- MDU accepted in cycle N is poppable at earliest in N+1, giving rf_we in N+2 when no WB write competes.
- There is no bypass from the MDU input to the port.
- rst asserted mid-operation flushes the FIFO, drops any pending entries, and clears the counter on that edge.
- Back-to-back WB writes hold the port indefinitely unless STARVE_EN is defined.

## Configuration
- WB_ARB_STARVE_EN defined:
  - A counter increments each cycle a live head exists but is not popped. It resets on any pop or when the FIFO is empty.
  - When the count reaches STARVE_LIMIT, stall_req is 1 in the next cycle. That cycle the head is guaranteed the port, and WB inputs are ignored; the pipeline re-presents them.
  - stall_req returns to 0 the cycle after, and the counter clears.
- WB_ARB_STARVE_EN undefined: stall_req is tied 0, no counter exists, and WB always has priority.

## Test plan
- Reset, then WB write $5=0x1234 → next cycle rf_we=1, rf_waddr=5, rf_wdata=0x1234; mdu_ready=1.
- MDU pushes $8=0xAA and $9=0xBB with WB idle → rf_we for $8 then $9 in consecutive cycles; mdu_ready=0 only while both entries are held (DEPTH=2).
- MDU $7=0x11 buffered, then WB writes $7=0x22 → entry is squashed. chk_pending(7) falls to 0, and the port shows only 0x22.
- WB writes $0 and MDU pushes to $0 → rf_we stays 0 and the FIFO stays empty.
- WB_ARB_STARVE_EN, STARVE_LIMIT=3, continuous WB writes and one MDU entry → stall_req=1 in the 4th waiting cycle, the MDU entry is written that cycle, and WB resumes the next cycle.
- rst asserted with FIFO full → next cycle FIFO empty, chk_pending=0, rf_we=0, mdu_ready=1 once rst is released.

Source files
------------

// File: rtl/wb_write_arbiter_if.sv
// Bundle of signals between WB stage / MDU / hazard logic and the write-port arbiter.
// Latency: none (wires only).
// Backpressure: MDU side uses valid/ready; WB side is held by stall_req.
interface wb_write_arbiter_if;
    logic        wb_reg_write;
    logic [4:0]  wb_dest;
    logic [31:0] wb_data;
    logic        mdu_valid;
    logic [4:0]  mdu_dest;
    logic [31:0] mdu_data;
    logic        mdu_ready;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        stall_req;
    logic [4:0]  chk_addr;
    logic        chk_pending;

    // Arbiter side
    modport slave (
        input  wb_reg_write, wb_dest, wb_data,
        input  mdu_valid, mdu_dest, mdu_data,
        input  chk_addr,
        output mdu_ready, rf_we, rf_waddr, rf_wdata, stall_req, chk_pending
    );

    // Pipeline / MDU / hazard side
    modport master (
        output wb_reg_write, wb_dest, wb_data,
        output mdu_valid, mdu_dest, mdu_data,
        output chk_addr,
        input  mdu_ready, rf_we, rf_waddr, rf_wdata, stall_req, chk_pending
    );
endinterface

// File: rtl/wb_write_arbiter.sv
// Shares the register-file write port between WB (priority) and a small MDU result FIFO.
// Latency: WB request -> rf_we next cycle; MDU accept -> rf_we two cycles later at best.
// Backpressure: mdu_ready=!full; optional WB_ARB_STARVE_EN raises stall_req to let a starved head through.
module wb_write_arbiter #(
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 8
) (
    input  logic clk,
    input  logic rst,
    wb_write_arbiter_if.slave bus
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [AW-1:0]    rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [AW:0]      cnt_q, cnt_d;
    logic [DEPTH-1:0] live_q, live_d;
    logic [4:0]       dest_q [DEPTH];
    logic [31:0]      data_q [DEPTH];

    logic        rf_we_q, rf_we_d;
    logic [4:0]  rf_waddr_q, rf_waddr_d;
    logic [31:0] rf_wdata_q, rf_wdata_d;
    logic        stall_q;

    logic full, head_vld, head_live, wb_req, pop, live_pop, push, pending;

    assign full      = (cnt_q == (AW+1)'(DEPTH));
    assign head_vld  = (cnt_q != '0);
    assign head_live = head_vld && live_q[rd_ptr_q];
    // A WB request is ignored while stall_req is up; the pipeline re-presents it.
    assign wb_req    = bus.wb_reg_write && (bus.wb_dest != 5'd0) && !stall_q;
    // Dead heads leave regardless of WB; live heads only when WB does not take the port.
    assign pop       = head_vld && (!head_live || !wb_req);
    assign live_pop  = pop && head_live;
    assign push      = bus.mdu_valid && bus.mdu_ready && (bus.mdu_dest != 5'd0);

    // FIFO bookkeeping, supersede marking and port selection
    always_comb begin
        live_d = live_q;
        for (int i = 0; i < DEPTH; i++) begin
            if (wb_req && dest_q[i] == bus.wb_dest) live_d[i] = 1'b0;
        end
        if (pop)  live_d[rd_ptr_q] = 1'b0;
        if (push) live_d[wr_ptr_q] = 1'b1;

        rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        cnt_d    = cnt_q + (AW+1)'(push) - (AW+1)'(pop);

        rf_we_d    = 1'b0;
        rf_waddr_d = rf_waddr_q;
        rf_wdata_d = rf_wdata_q;
        if (wb_req) begin
            rf_we_d    = 1'b1;
            rf_waddr_d = bus.wb_dest;
            rf_wdata_d = bus.wb_data;
        end else if (live_pop) begin
            rf_we_d    = 1'b1;
            rf_waddr_d = dest_q[rd_ptr_q];
            rf_wdata_d = data_q[rd_ptr_q];
        end
    end

    // Control state with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            cnt_q      <= '0;
            live_q     <= '0;
            rf_we_q    <= 1'b0;
            rf_waddr_q <= 5'd0;
            rf_wdata_q <= 32'd0;
        end else begin
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            cnt_q      <= cnt_d;
            live_q     <= live_d;
            rf_we_q    <= rf_we_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wdata_q <= rf_wdata_d;
        end
    end

    // Payload storage; validity is tracked by cnt_q/live_q so no reset needed
    always_ff @(posedge clk) begin
        if (push) begin
            dest_q[wr_ptr_q] <= bus.mdu_dest;
            data_q[wr_ptr_q] <= bus.mdu_data;
        end
    end

`ifdef WB_ARB_STARVE_EN
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    logic [SW-1:0] starve_q, starve_d;
    logic          stall_d;

    // Count cycles a live head is passed over; arm stall when the limit is reached
    always_comb begin
        starve_d = '0;
        stall_d  = 1'b0;
        if (head_live && !pop) begin
            starve_d = starve_q + SW'(1);
            stall_d  = (starve_d == SW'(STARVE_LIMIT));
        end
    end

    // Starvation counter and stall request registers
    always_ff @(posedge clk) begin
        if (rst) begin
            starve_q <= '0;
            stall_q  <= 1'b0;
        end else begin
            starve_q <= starve_d;
            stall_q  <= stall_d;
        end
    end
`else
    assign stall_q = 1'b0;
`endif

    // Hazard lookup over live entries only; $0 is never a hazard
    always_comb begin
        pending = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (live_q[i] && dest_q[i] == bus.chk_addr) pending = 1'b1;
        end
    end

    assign bus.chk_pending = pending && (bus.chk_addr != 5'd0);
    assign bus.mdu_ready   = !rst && !full;
    assign bus.rf_we       = rf_we_q;
    assign bus.rf_waddr    = rf_waddr_q;
    assign bus.rf_wdata    = rf_wdata_q;
    assign bus.stall_req   = stall_q;
endmodule

// File: tb/tb_wb_write_arbiter.sv
// Directed self-checking bench for wb_write_arbiter (DEPTH=2, STARVE_LIMIT=3).
// Inputs change 1ns after the rising edge; outputs are sampled at the same point.
module tb_wb_write_arbiter;
    logic clk = 1'b0;
    logic rst;
    int   vectors = 0;
    int   miscompares = 0;

`ifdef WB_ARB_STARVE_EN
    localparam bit STARVE_ON = 1'b1;
`else
    localparam bit STARVE_ON = 1'b0;
`endif

    wb_write_arbiter_if bus ();

    wb_write_arbiter #(.DEPTH(2), .STARVE_LIMIT(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wb(input logic en, input logic [4:0] d, input logic [31:0] v);
        bus.wb_reg_write = en;
        bus.wb_dest      = d;
        bus.wb_data      = v;
    endtask

    task automatic mdu(input logic en, input logic [4:0] d, input logic [31:0] v);
        bus.mdu_valid = en;
        bus.mdu_dest  = d;
        bus.mdu_data  = v;
    endtask

    task automatic port(input string tag, input logic we, input logic [4:0] a, input logic [31:0] v);
        chk({tag, ".we"},    32'(bus.rf_we), 32'(we));
        chk({tag, ".waddr"}, 32'(bus.rf_waddr), 32'(a));
        chk({tag, ".wdata"}, bus.rf_wdata, v);
    endtask

    task automatic pend(input string tag, input logic [4:0] a, input logic exp);
        bus.chk_addr = a;
        #1;
        chk(tag, 32'(bus.chk_pending), 32'(exp));
    endtask

    initial begin
        rst = 1'b1;
        wb(0, 0, 0);
        mdu(0, 0, 0);
        bus.chk_addr = 0;
        tick();
        tick();
        // Reset state
        port("rst", 0, 0, 0);
        chk("rst.stall", 32'(bus.stall_req), 0);
        chk("rst.ready", 32'(bus.mdu_ready), 0);
        rst = 1'b0;
        #1;
        chk("post_rst.ready", 32'(bus.mdu_ready), 1);

        // Plain WB write
        wb(1, 5, 32'h1234);
        tick();
        wb(0, 0, 0);
        port("wb5", 1, 5, 32'h1234);
        chk("wb5.ready", 32'(bus.mdu_ready), 1);
        tick();
        port("idle_hold", 0, 5, 32'h1234);

        // Fill FIFO behind WB traffic, then drain 8 then 9
        mdu(1, 8, 32'hAA);
        wb(1, 3, 32'h33);
        tick();
        port("fill.wb3", 1, 3, 32'h33);
        mdu(1, 9, 32'hBB);
        wb(1, 4, 32'h44);
        chk("fill.ready1", 32'(bus.mdu_ready), 1);
        tick();
        port("fill.wb4", 1, 4, 32'h44);
        chk("full.ready", 32'(bus.mdu_ready), 0);
        wb(0, 0, 0);
        mdu(1, 10, 32'hCC);
        pend("full.pend8", 8, 1);
        pend("full.pend9", 9, 1);
        tick();
        mdu(0, 0, 0);
        port("drain8", 1, 8, 32'hAA);
        chk("drain8.ready", 32'(bus.mdu_ready), 1);
        tick();
        port("drain9", 1, 9, 32'hBB);
        tick();
        chk("drained.we", 32'(bus.rf_we), 0);
        pend("rejected.pend10", 10, 0);

        // Supersede: buffered $7 is squashed by WB $7
        mdu(1, 7, 32'h11);
        wb(1, 6, 32'h66);
        tick();
        mdu(0, 0, 0);
        port("sq.wb6", 1, 6, 32'h66);
        pend("sq.pend7_before", 7, 1);
        wb(1, 7, 32'h22);
        tick();
        wb(0, 0, 0);
        port("sq.wb7", 1, 7, 32'h22);
        pend("sq.pend7_after", 7, 0);
        tick();
        port("sq.dead_pop", 0, 7, 32'h22);
        tick();
        port("sq.empty", 0, 7, 32'h22);

        // Writes to $0 from both sources are discarded
        wb(1, 0, 32'hDEAD);
        mdu(1, 0, 32'hBEEF);
        #1;
        chk("zero.ready", 32'(bus.mdu_ready), 1);
        tick();
        wb(0, 0, 0);
        mdu(0, 0, 0);
        port("zero.wb", 0, 7, 32'h22);
        tick();
        port("zero.mdu", 0, 7, 32'h22);
        pend("zero.pend0", 0, 0);

        // Continuous WB with one waiting MDU entry
        mdu(1, 12, 32'hC0);
        wb(1, 1, 32'h100);
        tick();
        mdu(0, 0, 0);
        port("stv.w0", 1, 1, 32'h100);
        for (int k = 1; k <= 5; k++) begin
            wb(1, 1, 32'h100 + 32'(k));
            tick();
            chk($sformatf("stv.stall%0d", k), 32'(bus.stall_req), 32'(STARVE_ON && k == 3));
            if (STARVE_ON && k == 4)
                port($sformatf("stv.port%0d", k), 1, 12, 32'hC0);
            else
                port($sformatf("stv.port%0d", k), 1, 1, 32'h100 + 32'(k));
        end
        wb(0, 0, 0);
        pend("stv.pend12", 12, !STARVE_ON);
        tick();
        if (STARVE_ON)
            port("stv.after", 0, 1, 32'h105);
        else
            port("stv.after", 1, 12, 32'hC0);
        tick();

        // Reset while full flushes everything
        wb(1, 2, 32'h2);
        mdu(1, 13, 32'hD1);
        tick();
        mdu(1, 14, 32'hD2);
        tick();
        mdu(0, 0, 0);
        chk("rstfull.ready", 32'(bus.mdu_ready), 0);
        pend("rstfull.pend13", 13, 1);
        wb(0, 0, 0);
        rst = 1'b1;
        tick();
        port("rstfull.port", 0, 0, 0);
        chk("rstfull.ready_in_rst", 32'(bus.mdu_ready), 0);
        pend("rstfull.pend13_gone", 13, 0);
        pend("rstfull.pend14_gone", 14, 0);
        rst = 1'b0;
        #1;
        chk("rstfull.ready_after", 32'(bus.mdu_ready), 1);
        tick();
        chk("rstfull.no_pop", 32'(bus.rf_we), 0);
        tick();
        chk("rstfull.no_pop2", 32'(bus.rf_we), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
